sys_bus: RTL and testbench
==========================

SYS_BUS -- requirements
Module: sys_bus

Interface
REQ-001 SHALL have parameter DMA_CPB, default 4, meaning clocks per DMA byte, legal range 2..8.
REQ-002 SHALL have parameter DMA_LEN, default 160, meaning bytes per OAM DMA.
REQ-003 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports r_addr in 16, r_data out 8, w_addr in 16, w_data in 8, w_wen in 1: core-facing read/write ports.
REQ-006 SHALL have ports mem_addr out 16, mem_wdata out 8, mem_wen out 1, mem_rdata in 8: external single-port bus, combinational read.
REQ-007 SHALL have ports ie out 8 (interrupt-enable register) and dma_active out 1.

Function
REQ-008 SHALL decode HRAM 0xFF80-0xFFFE (127 B internal array), IE 0xFFFF, DMA 0xFF46; all other addresses are external.
REQ-009 SHALL return r_data registered: value for r_addr sampled at edge N appears after edge N, i.e. 1-clock latency.
REQ-010 SHALL serve HRAM/IE/DMA reads internally; DMA register reads return the last written value.
REQ-011 SHALL perform internal writes when w_wen=1 at the clock edge; HRAM read and write to the same address in one cycle return the old data.
REQ-012 SHALL, when idle and w_wen=1 to an external address, drive mem_addr=w_addr, mem_wdata=w_data, mem_wen=1; otherwise mem_addr=r_addr, mem_wen=0.
REQ-013 SHALL, on a simultaneous external read and external write, give the write the bus and return 0xFF for that read.
REQ-014 SHALL implement the DMA FSM: IDLE -> START on a write to 0xFF46; START lasts DMA_CPB clocks, then COPY; COPY -> IDLE after byte DMA_LEN-1 completes.
REQ-015 SHALL, in COPY, process byte n (0..DMA_LEN-1) over DMA_CPB clocks: phase 0 drives mem_addr={src,8'h00}+n and captures mem_rdata; phase 1 drives mem_addr=0xFE00+n, mem_wdata=captured byte, mem_wen=1; remaining phases leave the bus idle (mem_wen=0).
REQ-016 SHALL hold dma_active=1 in START and COPY.
REQ-017 SHALL, in COPY, return 0xFF for core reads outside HRAM/IE/0xFF46 and drop core writes to external addresses; internal accesses proceed normally.
REQ-018 SHALL, on a write to 0xFF46 during START or COPY, latch the new source, zero the byte counter and re-enter START.
REQ-019 SHALL compute n and phase counters with no wrap beyond DMA_LEN-1 and DMA_CPB-1, respectively.

Reset
REQ-020 SHALL, on rst, set state=IDLE, counters=0, dma_active=0, ie=0x00, DMA register=0xFF, r_data=0xFF, mem_wen=0, and mem_addr=r_addr.
REQ-021 SHALL leave HRAM contents unreset.
REQ-022 SHALL abort a DMA on rst assertion mid-transfer with no further mem_wen pulse; after release, state is IDLE.

Structure
REQ-023 SHALL place the address constants (HRAM_BASE/END, ADDR_IE, ADDR_DMA, OAM_BASE) and the dma_state_t enum in sm83_pkg.
REQ-024 SHALL isolate the DMA FSM and counters in the sub-module oam_dma; the decode, HRAM, IE and muxing logic stays in sys_bus.

Verification
REQ-025 SHALL verify: write 0x5A to 0xFF90, then read 0xFF90 -> r_data=0x5A one clock later, with mem_wen never asserted.
REQ-026 SHALL verify: write 0x1F to 0xFFFF -> ie=0x1F; a read of 0xFFFF returns 0x1F.
REQ-027 SHALL verify: preload external 0xC000+n=n, write 0xC0 to 0xFF46 -> dma_active high for 4+160*4=644 clocks, 160 writes 0xFE00+n=n in order, then IDLE.
REQ-028 SHALL verify: during COPY, a core read of 0x8000 returns 0xFF, a core read of 0xFF80 returns HRAM data, and a core write to 0xC100 produces no core-originated mem_wen.
REQ-029 SHALL verify: a write of 0xD0 to 0xFF46 at byte 50 -> restart, after which the next 160 writes source 0xD000-0xD09F starting at 0xFE00.
REQ-030 SHALL verify: rst asserted at byte 80 -> dma_active=0 and mem_wen=0 immediately; reads of 0xFF46 return 0xFF after release.

Source files
------------

// File: rtl/sm83_pkg.sv
// sm83_pkg: shared address map constants, DMA state enum and address decode helpers.
//   HRAM_BASE/HRAM_END : internal high-RAM window
//   ADDR_IE / ADDR_DMA : interrupt-enable and OAM DMA source registers
//   OAM_BASE           : OAM DMA destination base
package sm83_pkg;
    localparam logic [15:0] HRAM_BASE = 16'hFF80;
    localparam logic [15:0] HRAM_END  = 16'hFFFE;
    localparam logic [15:0] ADDR_IE   = 16'hFFFF;
    localparam logic [15:0] ADDR_DMA  = 16'hFF46;
    localparam logic [15:0] OAM_BASE  = 16'hFE00;

    typedef enum logic [1:0] {DMA_IDLE, DMA_START, DMA_COPY} dma_state_t;

    function automatic logic is_hram(input logic [15:0] a);
        return a >= HRAM_BASE && a <= HRAM_END;
    endfunction

    function automatic logic is_ext(input logic [15:0] a);
        return !is_hram(a) && a != ADDR_IE && a != ADDR_DMA;
    endfunction
endpackage

// File: rtl/sys_bus_oam_dma.sv
// oam_dma: OAM DMA sequencer, copies LEN bytes from {src,8'h00} to OAM_BASE.
//   clk, rst       : clock, async active-high reset
//   start          : write to the DMA register (starts or restarts a transfer)
//   src            : source page (current DMA register value)
//   rdata          : external bus read data
//   active, copy   : transfer in progress / in COPY state
//   bus, addr,
//   wdata, wen     : bus request and the bus values to drive while granted
module oam_dma import sm83_pkg::*; #(
    parameter int CPB = 4,
    parameter int LEN = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  src,
    input  logic [7:0]  rdata,
    output logic        active,
    output logic        copy,
    output logic        bus,
    output logic [15:0] addr,
    output logic [7:0]  wdata,
    output logic        wen
);
    localparam int NW = $clog2(LEN) > 0 ? $clog2(LEN) : 1;
    localparam int PW = $clog2(CPB);
    localparam logic [NW-1:0] N_LAST = NW'(LEN - 1);
    localparam logic [PW-1:0] P_LAST = PW'(CPB - 1);

    dma_state_t state, state_d;
    logic [NW-1:0] n, n_d;
    logic [PW-1:0] ph, ph_d;
    logic [7:0] data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= DMA_IDLE;
            n     <= '0;
            ph    <= '0;
            data  <= '0;
        end else begin
            state <= state_d;
            n     <= n_d;
            ph    <= ph_d;
            // phase 0 has the source byte on the bus; hold it for the phase-1 write
            data  <= (state == DMA_COPY && ph == '0) ? rdata : data;
        end
    end

    always_comb begin
        state_d = state;
        n_d     = n;
        ph_d    = ph;
        if (start) begin
            state_d = DMA_START;
            n_d     = '0;
            ph_d    = '0;
        end else if (state != DMA_IDLE) begin
            ph_d = ph == P_LAST ? '0 : ph + 1'b1;
            if (ph == P_LAST) begin
                if (state == DMA_START) begin
                    state_d = DMA_COPY;
                end else begin
                    state_d = n == N_LAST ? DMA_IDLE : DMA_COPY;
                    n_d     = n == N_LAST ? '0 : n + 1'b1;
                end
            end
        end
        active = state != DMA_IDLE;
        copy   = state == DMA_COPY;
        bus    = copy && (ph == '0 || ph == PW'(1));
        addr   = ph == '0 ? {src, 8'h00} + 16'(n) : OAM_BASE + 16'(n);
        wdata  = data;
        wen    = copy && ph == PW'(1);
    end
endmodule

// File: rtl/sys_bus.sv
// sys_bus: core-facing bus with HRAM, IE, OAM DMA register and external bus muxing.
//   clk, rst                     : clock, async active-high reset
//   r_addr, r_data               : core read port, 1-clock registered latency
//   w_addr, w_data, w_wen        : core write port
//   mem_addr, mem_wdata,
//   mem_wen, mem_rdata           : external single-port bus, combinational read
//   ie                           : interrupt-enable register
//   dma_active                   : OAM DMA in START or COPY
module sys_bus import sm83_pkg::*; #(
    parameter int DMA_CPB = 4,
    parameter int DMA_LEN = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] r_addr,
    output logic [7:0]  r_data,
    input  logic [15:0] w_addr,
    input  logic [7:0]  w_data,
    input  logic        w_wen,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_wen,
    input  logic [7:0]  mem_rdata,
    output logic [7:0]  ie,
    output logic        dma_active
);
    logic [7:0] hram [0:126];
    logic [7:0] dma_reg, r_next, dma_wdata;
    logic [15:0] dma_addr;
    logic dma_start, dma_copy, dma_bus, dma_wen, core_wen;

    assign dma_start = w_wen && w_addr == ADDR_DMA;
    // external core writes are dropped while DMA owns the bus
    assign core_wen  = w_wen && is_ext(w_addr) && !dma_copy;

    oam_dma #(.CPB(DMA_CPB), .LEN(DMA_LEN)) u_dma (
        .clk    (clk),
        .rst    (rst),
        .start  (dma_start),
        .src    (dma_reg),
        .rdata  (mem_rdata),
        .active (dma_active),
        .copy   (dma_copy),
        .bus    (dma_bus),
        .addr   (dma_addr),
        .wdata  (dma_wdata),
        .wen    (dma_wen)
    );

    always_comb begin
        mem_addr  = rst ? r_addr : dma_bus ? dma_addr : core_wen ? w_addr : r_addr;
        mem_wdata = dma_bus ? dma_wdata : w_data;
        mem_wen   = !rst && (dma_bus ? dma_wen : core_wen);
        // external read data is unusable when the bus carries a write or DMA traffic
        r_next    = is_hram(r_addr)       ? hram[r_addr[6:0]] :
                    r_addr == ADDR_IE     ? ie :
                    r_addr == ADDR_DMA    ? dma_reg :
                    (dma_copy || core_wen) ? 8'hFF : mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data  <= 8'hFF;
            ie      <= 8'h00;
            dma_reg <= 8'hFF;
        end else begin
            r_data <= r_next;
            if (w_wen && w_addr == ADDR_IE) ie <= w_data;
            if (dma_start) dma_reg <= w_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wen && is_hram(w_addr)) hram[w_addr[6:0]] <= w_data;
    end
endmodule

// File: tb/tb_sys_bus.sv
// tb_sys_bus: directed self-checking bench for sys_bus with an external memory model.
module tb_sys_bus;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] r_addr = 16'h1234;
    logic [7:0]  r_data;
    logic [15:0] w_addr = 16'hC000;
    logic [7:0]  w_data = 8'h00;
    logic        w_wen = 1'b1;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_wen;
    logic [7:0]  mem_rdata;
    logic [7:0]  ie;
    logic        dma_active;

    logic [7:0]  ext [0:65535];
    logic [23:0] wlog [$];
    int n_chk = 0;
    int n_fail = 0;
    int cnt, k;

    sys_bus dut (
        .clk        (clk),
        .rst        (rst),
        .r_addr     (r_addr),
        .r_data     (r_data),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .w_wen      (w_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wen    (mem_wen),
        .mem_rdata  (mem_rdata),
        .ie         (ie),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;

    assign mem_rdata = ext[mem_addr];

    always @(posedge clk) begin
        if (mem_wen) begin
            ext[mem_addr] = mem_wdata;
            wlog.push_back({mem_addr, mem_wdata});
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic start_dma(input logic [7:0] src);
        w_addr = 16'hFF46;
        w_data = src;
        w_wen  = 1'b1;
        tick();
        w_wen  = 1'b0;
    endtask

    task automatic wait_log(input int target);
        for (int i = 0; i < 2000 && wlog.size() < target; i++) tick();
        check("wait_log", wlog.size(), target);
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ext[i] = 8'h00;
        ext[16'h8000] = 8'h55;
        ext[16'hC100] = 8'h11;
        for (int i = 0; i < 160; i++) begin
            ext[16'hC000 + i] = 8'(i);
            ext[16'hD000 + i] = 8'(i) ^ 8'hA5;
        end

        // reset state, with an external write pending to prove gating
        tick();
        tick();
        check("rst_r_data", r_data, 8'hFF);
        check("rst_ie", ie, 8'h00);
        check("rst_dma_active", dma_active, 1'b0);
        check("rst_mem_wen", mem_wen, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h1234);
        w_wen = 1'b0;
        rst = 1'b0;
        r_addr = 16'hFF46;
        tick();
        check("rst_dma_reg", r_data, 8'hFF);

        // HRAM write/read, old data on same-cycle read/write
        wlog.delete();
        w_addr = 16'hFF90; w_data = 8'h5A; w_wen = 1'b1; r_addr = 16'hFF90;
        tick();
        w_wen = 1'b0;
        tick();
        check("hram_rd", r_data, 8'h5A);
        w_data = 8'h77; w_wen = 1'b1;
        tick();
        check("hram_old", r_data, 8'h5A);
        w_wen = 1'b0;
        tick();
        check("hram_new", r_data, 8'h77);
        w_addr = 16'hFF80; w_data = 8'h42; w_wen = 1'b1;
        tick();
        w_wen = 1'b0;
        check("hram_no_wen", wlog.size(), 0);

        // IE register
        w_addr = 16'hFFFF; w_data = 8'h1F; w_wen = 1'b1;
        tick();
        w_wen = 1'b0;
        check("ie_reg", ie, 8'h1F);
        r_addr = 16'hFFFF;
        tick();
        check("ie_rd", r_data, 8'h1F);

        // external write with simultaneous external read
        r_addr = 16'h8000; w_addr = 16'hC123; w_data = 8'h3C; w_wen = 1'b1;
        #1;
        check("ext_w_addr", mem_addr, 16'hC123);
        check("ext_w_wen", mem_wen, 1'b1);
        check("ext_w_data", mem_wdata, 8'h3C);
        tick();
        check("ext_rw_ff", r_data, 8'hFF);
        w_wen = 1'b0;
        #1;
        check("ext_r_addr", mem_addr, 16'h8000);
        check("ext_r_wen", mem_wen, 1'b0);
        r_addr = 16'hC123;
        tick();
        check("ext_rd_back", r_data, 8'h3C);
        r_addr = 16'h8000;
        tick();
        check("ext_rd", r_data, 8'h55);

        // full OAM DMA from 0xC000 with core traffic during COPY
        wlog.delete();
        r_addr = 16'hFF46;
        start_dma(8'hC0);
        cnt = 0;
        for (int i = 0; i < 2000; i++) begin
            if (!dma_active) break;
            cnt++;
            if (i == 1) check("dma_reg_rd", r_data, 8'hC0);
            if (i == 100) r_addr = 16'h8000;
            if (i == 101) begin
                check("copy_ext_rd", r_data, 8'hFF);
                r_addr = 16'hFF80;
            end
            if (i == 102) begin
                check("copy_hram_rd", r_data, 8'h42);
                w_addr = 16'hC100; w_data = 8'h99; w_wen = 1'b1;
            end
            if (i == 103) w_wen = 1'b0;
            tick();
        end
        check("dma_active_len", cnt, 644);
        check("dma_count", wlog.size(), 160);
        for (int i = 0; i < 160 && i < wlog.size(); i++)
            check($sformatf("dma_wr%0d", i), wlog[i], {16'hFE00 + 16'(i), 8'(i)});
        check("copy_drop_wr", ext[16'hC100], 8'h11);

        // restart at byte 50 with a new source page
        wlog.delete();
        start_dma(8'hC0);
        wait_log(50);
        start_dma(8'hD0);
        check("restart_at", wlog.size(), 50);
        for (int i = 0; i < 2000 && dma_active; i++) tick();
        check("restart_idle", dma_active, 1'b0);
        check("restart_count", wlog.size(), 210);
        for (int i = 0; i < 160 && 50 + i < wlog.size(); i++)
            check($sformatf("restart_wr%0d", i), wlog[50 + i], {16'hFE00 + 16'(i), 8'(i) ^ 8'hA5});
        r_addr = 16'hFF46;
        tick();
        check("restart_reg", r_data, 8'hD0);

        // reset abort at byte 80
        wlog.delete();
        start_dma(8'hC0);
        wait_log(80);
        rst = 1'b1;
        #1;
        check("abort_active", dma_active, 1'b0);
        check("abort_wen", mem_wen, 1'b0);
        k = wlog.size();
        tick();
        tick();
        rst = 1'b0;
        r_addr = 16'hFF46;
        tick();
        check("abort_dma_reg", r_data, 8'hFF);
        check("abort_ie", ie, 8'h00);
        repeat (20) tick();
        check("abort_idle", dma_active, 1'b0);
        check("abort_no_wen", wlog.size(), k);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
